// File: rtl/mux_piso_sequencer.sv
// Parallel-to-serial front end for the WIDTH:1 index mux. It holds a captured
// word stable on `word` and walks `sel` through every index, one index per
// accepted serial beat. It frames the selected bit with valid/ready/last.
//
// state | meaning
// IDLE  | ready for a new word; no serial beat is presented
// SHIFT | word held; presenting word[sel] until the last beat is accepted
module mux_piso_sequencer #(
  parameter int N         = 4,
  parameter int WIDTH     = 2**N,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] word,
  output logic [N-1:0]     sel,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_ready
);

  localparam logic [N-1:0] START_SEL = MSB_FIRST ? {N{1'b1}} : {N{1'b0}};
  localparam logic [N-1:0] LAST_CNT  = {N{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_word;
  logic [N-1:0]     r_sel;
  logic [N-1:0]     r_count;
  logic             w_capture;
  logic             w_beat;
  logic             w_last;

  assign w_last  = (r_count == LAST_CNT);
  assign word    = r_word;
  assign sel     = r_sel;
  assign ser_out = r_word[r_sel];

  // State register; a synchronous reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    ser_valid   = 1'b0;
    ser_last    = 1'b0;
    w_capture   = 1'b0;
    w_beat      = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_last  = w_last;
        if (ser_ready) begin
          w_beat = 1'b1;
          if (w_last) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Word capture and index stepping; everything freezes while the beat is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_word  <= {WIDTH{1'b0}};
      r_sel   <= START_SEL;
      r_count <= {N{1'b0}};
    end else if (w_capture) begin
      r_word  <= in_data;
      r_sel   <= START_SEL;
      r_count <= {N{1'b0}};
    end else if (w_beat) begin
      if (w_last) begin
        r_sel   <= START_SEL;
        r_count <= {N{1'b0}};
      end else begin
        r_sel   <= MSB_FIRST ? (r_sel - N'(1)) : (r_sel + N'(1));
        r_count <= r_count + N'(1);
      end
    end
  end

endmodule

// File: tb/tb_mux_piso_sequencer.sv
// Bench for mux_piso_sequencer. It runs an LSB-first instance and an
// MSB-first instance side by side on the same stimulus. Expected beats come
// from the emission order: beat k carries bit k, or bit WIDTH-1-k when MSB
// first.
module tb_mux_piso_sequencer;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         ser_ready;

  logic [1:0]   in_ready;
  logic [1:0]   ser_out;
  logic [1:0]   ser_valid;
  logic [1:0]   ser_last;
  logic [W-1:0] word_o [2];
  logic [N-1:0] sel_o  [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_piso_sequencer #(.N(N), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready[0]), .word(word_o[0]), .sel(sel_o[0]),
    .ser_out(ser_out[0]), .ser_valid(ser_valid[0]), .ser_last(ser_last[0]),
    .ser_ready(ser_ready)
  );

  mux_piso_sequencer #(.N(N), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready[1]), .word(word_o[1]), .sel(sel_o[1]),
    .ser_out(ser_out[1]), .ser_valid(ser_valid[1]), .ser_last(ser_last[1]),
    .ser_ready(ser_ready)
  );

  // Index emitted on beat k by instance m (0 = LSB first, 1 = MSB first).
  function automatic int beat_index(input int m, input int k);
    return (m == 1) ? (W - 1 - k) : k;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle-state expectations shared by reset and end-of-word points.
  task automatic check_idle(input string tag, input logic [W-1:0] exp_word);
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (in_ready[m] !== 1'b1) begin
        n_fail++;
        $display("FAIL %s in_ready dut%0d: got %b expected 1", tag, m, in_ready[m]);
      end
      n_checks++;
      if (ser_valid[m] !== 1'b0 || ser_last[m] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s valid/last dut%0d: got %b/%b expected 0/0", tag, m, ser_valid[m], ser_last[m]);
      end
      n_checks++;
      if (sel_o[m] !== N'(beat_index(m, 0))) begin
        n_fail++;
        $display("FAIL %s sel dut%0d: got %0d expected %0d", tag, m, sel_o[m], beat_index(m, 0));
      end
      n_checks++;
      if (word_o[m] !== exp_word) begin
        n_fail++;
        $display("FAIL %s word dut%0d: got %h expected %h", tag, m, word_o[m], exp_word);
      end
    end
  endtask

  // Sends one word and follows it beat by beat.
  // mode 0: ready high, latency checked    mode 1: random backpressure
  // mode 2: in_valid pulse at beat arg     mode 3: reset at beat arg
  // mode 4: three stall cycles at beat arg
  task automatic run_word(input string tag, input logic [W-1:0] d, input int mode, input int arg);
    int k;
    int cyc;
    int stall;
    int idx;
    check_idle({tag, "_pre"}, word_o[0]);
    in_valid  = 1'b1;
    in_data   = d;
    ser_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = W'($urandom);
    cyc   = 1;
    k     = 0;
    stall = 0;
    while (k < W) begin
      if (cyc > 300) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s timeout: got %0d beats expected %0d", tag, k, W);
        return;
      end
      for (int m = 0; m < 2; m++) begin
        idx = beat_index(m, k);
        n_checks++;
        if (ser_valid[m] !== 1'b1 || in_ready[m] !== 1'b0) begin
          n_fail++;
          $display("FAIL %s valid/ready dut%0d beat%0d: got %b/%b expected 1/0", tag, m, k, ser_valid[m], in_ready[m]);
        end
        n_checks++;
        if (sel_o[m] !== N'(idx)) begin
          n_fail++;
          $display("FAIL %s sel dut%0d beat%0d: got %0d expected %0d", tag, m, k, sel_o[m], idx);
        end
        n_checks++;
        if (ser_out[m] !== d[idx]) begin
          n_fail++;
          $display("FAIL %s ser_out dut%0d beat%0d: got %b expected %b", tag, m, k, ser_out[m], d[idx]);
        end
        n_checks++;
        if (ser_last[m] !== (k == W - 1)) begin
          n_fail++;
          $display("FAIL %s ser_last dut%0d beat%0d: got %b expected %b", tag, m, k, ser_last[m], (k == W - 1));
        end
        n_checks++;
        if (word_o[m] !== d) begin
          n_fail++;
          $display("FAIL %s word dut%0d beat%0d: got %h expected %h", tag, m, k, word_o[m], d);
        end
      end
      ser_ready = 1'b1;
      case (mode)
        1: ser_ready = ($urandom_range(3) != 0);
        2: if (k == arg) begin
             in_valid = 1'b1;
             in_data  = ~d;
           end
        3: if (k == arg) begin
             rst_n = 1'b0;
             tick();
             check_idle({tag, "_abort"}, '0);
             rst_n = 1'b1;
             return;
           end
        4: if (k == arg && stall < 3) begin
             ser_ready = 1'b0;
             stall++;
           end
        default: ;
      endcase
      tick();
      cyc++;
      in_valid = 1'b0;
      if (ser_ready) k++;
    end
    check_idle({tag, "_post"}, d);
    if (mode == 0) begin
      n_checks++;
      if (cyc != W + 1) begin
        n_fail++;
        $display("FAIL %s latency: got %0d cycles expected %0d", tag, cyc, W + 1);
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    ser_ready = 1'b1;
    tick();
    tick();
    check_idle("reset", 16'h0000);
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    tick();
    tick();
    check_idle("reset_hold", 16'h0000);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    check_idle("reset_release", 16'h0000);
  endtask

  task automatic test_basic();
    run_word("basic", 16'h5ABD, 0, 0);
  endtask

  task automatic test_backpressure();
    run_word("stall13", 16'h5ABD, 4, 13);
  endtask

  task automatic test_ignore_in_valid();
    run_word("ignore", 16'h0000, 2, 5);
  endtask

  task automatic test_abort();
    run_word("abort", 16'h5ABD, 3, 7);
    run_word("after_abort", 16'h0001, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) run_word("b2b", W'($urandom), 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) run_word("random", W'($urandom), 1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_ignore_in_valid();
    test_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_piso_sequencer.md
Name: mux_piso_sequencer

Overview:
- Upstream driver for the team's WIDTH:1 index multiplexer.
- Accepts a parallel word through a valid/ready handshake and holds it stable.
- Steps the select index through every position, one per accepted output beat, and presents the selected bit as a serial stream with valid/ready/last framing.
- Makes the mux usable as a parallel-to-serial converter between a parallel producer and a bit-serial consumer.

Parameters:
- N, 4, select width in bits.
- WIDTH, 2**N, word width; derived, not overridden independently.
- MSB_FIRST, 0, 0 = emit index 0 first; 1 = emit index WIDTH-1 first.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- word  output  WIDTH  held copy of the accepted word; feeds the mux data input.
- sel  output  N  current index; feeds the mux select input.
- ser_out  output  1  word[sel]; internal selection equal to the mux output.
- ser_valid  output  1  ser_out is a valid beat.
- ser_last  output  1  current beat is the final bit of the word.
- ser_ready  input  1  downstream accepts the beat this cycle.

Behaviour:
- Reset (rst_n low at a clock edge):
  - State goes to IDLE; word=0; sel=start index (0, or WIDTH-1 if MSB_FIRST); beat count=0.
  - ser_valid=0, ser_last=0, in_ready=1 from the first cycle after reset.
  - Reset mid-word aborts the word. No partial completion; no ser_last is emitted.
- States: IDLE, SHIFT.
- IDLE:
  - in_ready=1, ser_valid=0.
  - On in_valid, capture in_data into word, load sel=start index and count=0, and go to SHIFT next cycle.
- SHIFT:
  - in_ready=0; ser_valid=1; ser_out=word[sel] (combinational from registers).
  - ser_last=1 when count==WIDTH-1.
  - Beat transfers when ser_valid && ser_ready. On transfer: count+1; sel+1 (or sel-1 if MSB_FIRST).
  - When the transfer has ser_last=1, go to IDLE next cycle.
  - sel wraps naturally in N bits. After the last beat, sel is reloaded to the start index on the return to IDLE.
- Backpressure: ser_ready low freezes sel, count, word and ser_out. The beat holds until accepted.
- word never changes while in SHIFT. in_valid in SHIFT is ignored and in_data is not captured.
- Latency:
  - First bit is valid one cycle after in_valid&&in_ready.
  - WIDTH beats per word with ser_ready held high.
  - One IDLE bubble between words, so throughput is WIDTH+1 cycles per word.
- ser_out, ser_last and sel are only meaningful while ser_valid=1. In IDLE, ser_out reflects word[start index].

Test Plan:
- Reset, then check: in_ready=1, ser_valid=0, sel=0, word=16'h0000. Then hold rst_n low with in_valid=1 and check nothing is captured.
- Send in_data=16'h5ABD, ser_ready=1, MSB_FIRST=0:
  - ser_valid rises one cycle later.
  - Expected ser_out sequence: 1,0,1,1,1,1,0,1,0,1,0,1,1,0,1,0.
  - sel steps 0..15; ser_last=1 only on beat 16; IDLE follows with in_ready=1.
- Same word with ser_ready low for 3 cycles at sel=13: sel holds 13 and ser_out holds 0. Resume and check the remaining bits 1,0 and ser_last on sel=15.
- MSB_FIRST=1, in_data=16'h5ABD:
  - First beat sel=15, ser_out=0; sel=13 gives 0; sel=9 gives 1.
  - ser_last on sel=0 with ser_out=1.
- Pulse in_valid with in_data=16'hFFFF during SHIFT of 16'h0000: all 16 beats are 0, and word stays 16'h0000 throughout.
- Assert rst_n low at beat 7 of 16'h5ABD: next cycle ser_valid=0, in_ready=1, sel=0. A new word 16'h0001 then serializes as 1 followed by fifteen 0s.
